// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the 64-bit R-type datapath: fetch, decode,
// execute and writeback strobes, halt-on-trap with resume, retired-instruction count.
module mc_sequencer #(
  parameter int         CNT_W    = 32,
  parameter logic [6:0] OP_RTYPE = 7'b0110011,
  parameter logic [6:0] OP_ECALL = 7'b1110011
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [6:0]       opcode,
  input  logic             alu_invalid,
  output logic             ir_load,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             pc_write,
  output logic             halted,
  output logic [1:0]       trap_cause,
  input  logic             resume,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_ALU     = 2'd2;
  localparam logic [1:0] TRAP_ECALL   = 2'd3;
  localparam logic [1:0] ALUOP_IDLE   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             halted_r;
  logic [1:0]       trap_cause_r;
  logic [CNT_W-1:0] retired_r;

  logic             imem_req_s;
  logic             ir_load_s;
  logic [1:0]       alu_op_s;
  logic             wb_s;

  // State walk, trap capture and retirement counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_FETCH;
      halted_r     <= 1'b0;
      trap_cause_r <= TRAP_NONE;
      retired_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_ready) state_r <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == OP_RTYPE) begin
            state_r <= S_EXECUTE;
          end else begin
            state_r      <= S_HALT;
            halted_r     <= 1'b1;
            trap_cause_r <= (opcode == OP_ECALL) ? TRAP_ECALL : TRAP_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          if (alu_invalid) begin
            state_r      <= S_HALT;
            halted_r     <= 1'b1;
            trap_cause_r <= TRAP_ALU;
          end else begin
            state_r <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          state_r   <= S_FETCH;
          retired_r <= retired_r + CNT_ONE;
        end
        S_HALT: begin
          if (resume) begin
            state_r      <= S_FETCH;
            halted_r     <= 1'b0;
            trap_cause_r <= TRAP_NONE;
          end
        end
        default: begin
          state_r      <= S_FETCH;
          halted_r     <= 1'b0;
          trap_cause_r <= TRAP_NONE;
        end
      endcase
    end
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    imem_req_s = 1'b0;
    ir_load_s  = 1'b0;
    alu_op_s   = ALUOP_IDLE;
    wb_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        ir_load_s  = imem_ready;
      end
      S_DECODE, S_EXECUTE: begin
        alu_op_s = ALUOP_RTYPE;
      end
      S_WRITEBACK: begin
        alu_op_s = ALUOP_RTYPE;
        wb_s     = 1'b1;
      end
      default: begin
        imem_req_s = 1'b0;
        ir_load_s  = 1'b0;
        alu_op_s   = ALUOP_IDLE;
        wb_s       = 1'b0;
      end
    endcase
  end

  // Reset holds every output low, including the registered status
  always_comb begin
    if (rst) begin
      imem_req   = imem_req_s;
      ir_load    = ir_load_s;
      alu_op     = alu_op_s;
      reg_write  = wb_s;
      pc_write   = wb_s;
      halted     = halted_r;
      trap_cause = trap_cause_r;
      retired    = retired_r;
    end else begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      alu_op     = ALUOP_IDLE;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      halted     = 1'b0;
      trap_cause = TRAP_NONE;
      retired    = {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized scoreboard bench for mc_sequencer: an instruction-level model queues
// the expected outputs of every cycle, a negedge monitor pops and compares them.
module tb_mc_sequencer;

  localparam int         CNT_W = 4;
  localparam logic [6:0] OP_RT = 7'b0110011;
  localparam logic [6:0] OP_EC = 7'b1110011;

  logic             clk;
  logic             rst;
  logic             imem_req;
  logic             imem_ready;
  logic [6:0]       opcode;
  logic             alu_invalid;
  logic             ir_load;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             pc_write;
  logic             halted;
  logic [1:0]       trap_cause;
  logic             resume;
  logic [CNT_W-1:0] retired;

  mc_sequencer #(.CNT_W(CNT_W), .OP_RTYPE(OP_RT), .OP_ECALL(OP_EC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
    .opcode(opcode), .alu_invalid(alu_invalid), .ir_load(ir_load),
    .alu_op(alu_op), .reg_write(reg_write), .pc_write(pc_write),
    .halted(halted), .trap_cause(trap_cause), .resume(resume), .retired(retired)
  );

  typedef struct packed {
    logic       req;
    logic       irl;
    logic [1:0] aop;
    logic       rw;
    logic       pw;
    logic       hlt;
    logic [1:0] trap;
    logic [3:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Instruction-level model state: trap cause latched and instructions retired.
  int   m_trap    = 0;
  int   m_retired = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input bit req, input bit irl, input bit [1:0] aop,
                              input bit wb, input bit hlt);
    exp_t e;
    e.req  = req;
    e.irl  = irl;
    e.aop  = aop;
    e.rw   = wb;
    e.pw   = wb;
    e.hlt  = hlt;
    e.trap = 2'(m_trap);
    e.ret  = 4'(m_retired % 16);
    return e;
  endfunction

  // Monitor: every cycle the DUT presents a full output set; compare with the queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got_s, want_s;
      e = exp_q.pop_front();
      got_s  = {imem_req, ir_load, alu_op, reg_write, pc_write, halted};
      want_s = {e.req, e.irl, e.aop, e.rw, e.pw, e.hlt};
      total++;
      if (got_s !== want_s) begin
        bad++;
        $display("FAIL strobes t=%0t req,irl,aop,rw,pw,hlt got=%b want=%b", $time, got_s, want_s);
      end
      total++;
      if (trap_cause !== e.trap) begin
        bad++;
        $display("FAIL trap_cause t=%0t got=%0d want=%0d", $time, trap_cause, e.trap);
      end
      total++;
      if (retired !== e.ret) begin
        bad++;
        $display("FAIL retired t=%0t got=%0d want=%0d", $time, retired, e.ret);
      end
    end
  end

  task automatic step(input bit rdy, input bit inv, input bit res, input bit rs, input exp_t e);
    imem_ready  = rdy;
    alu_invalid = inv;
    resume      = res;
    rst         = rs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic halt_phase();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) step(rb(), rb(), 1'b0, 1'b1, mk(0, 0, 2'b00, 0, 1));
    step(rb(), rb(), 1'b1, 1'b1, mk(0, 0, 2'b00, 0, 1));
    m_trap = 0;
  endtask

  // kind: 0 R-type, 1 ECALL, 2 illegal opcode, 3 ALU invalid in EXECUTE
  task automatic run_instr(input int stalls, input int kind, input bit dec_inv, input logic [6:0] bad_op);
    logic [6:0] op;
    op = (kind == 1) ? OP_EC : (kind == 2) ? bad_op : OP_RT;
    for (int i = 0; i < stalls; i++) begin
      opcode = 7'($urandom);
      step(1'b0, rb(), rb(), 1'b1, mk(1, 0, 2'b00, 0, 0));
    end
    opcode = 7'($urandom);
    step(1'b1, rb(), rb(), 1'b1, mk(1, 1, 2'b00, 0, 0));
    opcode = op;
    step(rb(), dec_inv, rb(), 1'b1, mk(0, 0, 2'b10, 0, 0));
    if (kind == 1 || kind == 2) begin
      m_trap = (kind == 1) ? 3 : 1;
      halt_phase();
    end else begin
      step(rb(), kind == 3, rb(), 1'b1, mk(0, 0, 2'b10, 0, 0));
      if (kind == 3) begin
        m_trap = 2;
        halt_phase();
      end else begin
        step(rb(), rb(), rb(), 1'b1, mk(0, 0, 2'b10, 1, 0));
        m_retired = m_retired + 1;
      end
    end
  endtask

  // phase: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK, 4 HALT (after ECALL)
  task automatic reset_in(input int phase);
    int n;
    opcode = (phase == 4) ? OP_EC : OP_RT;
    if (phase >= 1) step(1'b1, rb(), rb(), 1'b1, mk(1, 1, 2'b00, 0, 0));
    if (phase >= 2) step(rb(), rb(), rb(), 1'b1, mk(0, 0, 2'b10, 0, 0));
    if (phase == 4) m_trap = 3;
    if (phase == 3) step(rb(), 1'b0, rb(), 1'b1, mk(0, 0, 2'b10, 0, 0));
    n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) step(1'b1, rb(), 1'b1, 1'b0, exp_t'(0));
    m_trap    = 0;
    m_retired = 0;
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    op = 7'($urandom);
    if (op == OP_RT || op == OP_EC) op = 7'b0000011;
    return op;
  endfunction

  initial begin
    int r;
    rst         = 1'b0;
    imem_ready  = 1'b1;
    alu_invalid = 1'b0;
    resume      = 1'b0;
    opcode      = 7'd0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b1, 1'b0, exp_t'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0, exp_t'(0));
    m_trap    = 0;
    m_retired = 0;

    run_instr(0, 0, 1'b0, OP_RT);
    run_instr(0, 0, 1'b0, OP_RT);
    run_instr(3, 0, 1'b0, OP_RT);
    run_instr(0, 2, 1'b0, 7'b0000011);
    run_instr(0, 3, 1'b0, OP_RT);
    run_instr(0, 0, 1'b1, OP_RT);
    run_instr(1, 1, 1'b0, OP_RT);
    for (int i = 0; i < 16; i++) run_instr(0, 0, 1'b0, OP_RT);
    reset_in(2);
    for (int p = 0; p < 5; p++) begin
      reset_in(p);
      run_instr(0, 0, 1'b0, OP_RT);
    end

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       reset_in($urandom_range(0, 4));
      else if (r < 65) run_instr($urandom_range(0, 3), 0, rb(), OP_RT);
      else if (r < 75) run_instr($urandom_range(0, 3), 1, rb(), OP_RT);
      else if (r < 87) run_instr($urandom_range(0, 3), 2, rb(), rand_illegal());
      else             run_instr($urandom_range(0, 3), 3, rb(), OP_RT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
